// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM with a posted store buffer and youngest-first load forwarding
module dmem_responder #(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int SB_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        adr_v_i,
  input  logic [XLEN-1:0]             adr_i,
  input  logic                        is_store_i,
  input  logic [XLEN-1:0]             store_data_i,
  input  logic [2:0]                  access_size_i,
  output logic [XLEN-1:0]             load_data_o,
  output logic [$clog2(SB_DEPTH):0]   sb_count_o,
  output logic                        sb_full_o,
  output logic                        drain_v_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = $clog2(SB_DEPTH);
  logic [XLEN-1:0]       r_ram [DEPTH];
  logic [SB_DEPTH-1:0]   r_sb_v;
  logic [DEPTH_LOG2-1:0] r_sb_idx [SB_DEPTH];
  logic [3:0]            r_sb_mask [SB_DEPTH];
  logic [XLEN-1:0]       r_sb_data [SB_DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [PW:0]           r_count;
  logic                  w_legal, w_load, w_store, w_drain, w_unused;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_off;
  logic [3:0]            w_mask;
  logic [XLEN-1:0]       w_sdata, w_merged, w_shift;
  assign w_legal  = access_size_i inside {3'b001, 3'b010, 3'b100};
  assign w_load   = adr_v_i & ~is_store_i & w_legal;
  assign w_store  = adr_v_i & is_store_i & w_legal;
  assign w_drain  = ~w_load & (r_count != '0);
  assign w_idx    = adr_i[DEPTH_LOG2+1:2];
  assign w_unused = ^adr_i[XLEN-1:DEPTH_LOG2+2];
  assign w_off    = access_size_i == 3'b100 ? 2'b00 :
                    access_size_i == 3'b010 ? {adr_i[1], 1'b0} : adr_i[1:0];
  assign w_mask   = access_size_i == 3'b100 ? 4'hF :
                    access_size_i == 3'b010 ? 4'b0011 << w_off : 4'b0001 << w_off;
  assign w_sdata  = store_data_i << {w_off, 3'b000};
  assign w_shift  = w_merged >> {w_off, 3'b000};
  assign sb_count_o = r_count;
  assign sb_full_o  = r_count == (PW+1)'(SB_DEPTH);
  assign drain_v_o  = w_drain;
  // RAM word overlaid oldest-to-youngest so the youngest matching byte wins
  always_comb begin
    w_merged = r_ram[w_idx];
    for (int k = 0; k < SB_DEPTH; k++)
      for (int b = 0; b < 4; b++)
        if (r_sb_v[r_head + PW'(k)] && r_sb_idx[r_head + PW'(k)] == w_idx && r_sb_mask[r_head + PW'(k)][b])
          w_merged[8*b +: 8] = r_sb_data[r_head + PW'(k)][8*b +: 8];
  end
  // right-justify and zero-extend to the access size; nothing is driven without a legal load
  always_comb begin
    load_data_o = !w_load ? '0 :
                  access_size_i == 3'b001 ? XLEN'(w_shift[7:0]) :
                  access_size_i == 3'b010 ? XLEN'(w_shift[15:0]) : w_shift;
  end
  // buffer control: a store in the same cycle as a drain reuses the freed slot when full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sb_v  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_sb_v[r_head] <= 1'b0;
        r_head         <= r_head + PW'(1);
      end
      if (w_store) begin
        r_sb_v[r_tail] <= 1'b1;
        r_tail         <= r_tail + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_store) - (PW+1)'(w_drain);
    end
  end
  // entry payload needs no reset; occupancy is governed by the valid bits
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_sb_idx[r_tail]  <= w_idx;
      r_sb_mask[r_tail] <= w_mask;
      r_sb_data[r_tail] <= w_sdata;
    end
  end
  // drain the head entry into RAM on non-load cycles, byte-masked
  always_ff @(posedge clk) begin
    if (w_drain)
      for (int b = 0; b < 4; b++)
        if (r_sb_mask[r_head][b])
          r_ram[r_sb_idx[r_head]][8*b +: 8] <= r_sb_data[r_head][8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed scoreboard bench against a byte-level memory model
module tb_dmem_responder;
  logic        clk = 1'b0, reset = 1'b1, adr_v_i = 1'b0, is_store_i = 1'b0;
  logic [31:0] adr_i = '0, store_data_i = '0, load_data_o;
  logic [2:0]  access_size_i = '0, sb_count_o;
  logic        sb_full_o, drain_v_o;

  typedef struct {logic [31:0] ld; int cnt; bit drn;} exp_t;
  typedef struct {int base; int n; logic [31:0] val;} st_t;

  exp_t       exp_q[$];
  st_t        pend[$];
  logic [7:0] mem [16384];
  exp_t       mon_e;
  int         checks = 0, failures = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .adr_v_i(adr_v_i), .adr_i(adr_i), .is_store_i(is_store_i),
    .store_data_i(store_data_i), .access_size_i(access_size_i), .load_data_o(load_data_o),
    .sb_count_o(sb_count_o), .sb_full_o(sb_full_o), .drain_v_o(drain_v_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // memory as the core sees it: committed bytes, then the youngest pending store covering the byte
  function automatic logic [7:0] view(int a);
    for (int j = pend.size() - 1; j >= 0; j--)
      if (a >= pend[j].base && a < pend[j].base + pend[j].n)
        return pend[j].val[8*(a - pend[j].base) +: 8];
    return mem[a];
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, int n);
    int base = int'(a & 32'h3FFF) & ~(n - 1);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = view(base + i);
    return r;
  endfunction

  task automatic step(bit v, bit st, logic [31:0] a, logic [31:0] d, logic [2:0] sz);
    exp_t e;
    st_t  s;
    bit   legal, ld, sr;
    int   n;
    @(posedge clk); #1;
    adr_v_i = v; is_store_i = st; adr_i = a; store_data_i = d; access_size_i = sz;
    n     = int'(sz);
    legal = (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4);
    ld    = v && !st && legal;
    sr    = v && st && legal;
    e.ld  = ld ? model_load(a, n) : 32'h0;
    e.cnt = pend.size();
    e.drn = !ld && pend.size() > 0;
    exp_q.push_back(e);
    if (e.drn) begin
      s = pend.pop_front();
      for (int i = 0; i < s.n; i++) mem[s.base + i] = s.val[8*i +: 8];
    end
    if (sr) begin
      s.base = int'(a & 32'h3FFF) & ~(n - 1);
      s.n    = n;
      s.val  = d;
      pend.push_back(s);
    end
  endtask

  task automatic pulse_reset();
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1; adr_v_i = 1'b0; is_store_i = 1'b0; access_size_i = 3'd0;
    pend.delete();
    e.ld = 32'h0; e.cnt = 0; e.drn = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("load_data", load_data_o, mon_e.ld);
      chk("sb_count", 32'(sb_count_o), 32'(mon_e.cnt));
      chk("sb_full", 32'(sb_full_o), 32'(mon_e.cnt == 4));
      chk("drain_v", 32'(drain_v_o), 32'(mon_e.drn));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    logic [2:0] sizes [8];
    logic [31:0] a;
    int op;
    sizes = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    e0.ld = 32'h0; e0.cnt = 0; e0.drn = 1'b0;
    exp_q.push_back(e0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int w = 0; w < 32; w++) step(1, 1, 32'(w * 4), $urandom, 3'd4);
    step(0, 0, 0, 0, 3'd0);
    // 1: word store then load
    step(1, 1, 32'h10, 32'hDEADBEEF, 3'd4);
    step(1, 0, 32'h10, 0, 3'd4);
    step(0, 0, 0, 0, 3'd0);
    step(1, 0, 32'h10, 0, 3'd4);
    // 2: back-to-back byte stores then word load
    for (int i = 0; i < 4; i++) step(1, 1, 32'h20 + 32'(i), 32'(8'h11 * (i + 1)), 3'd1);
    step(1, 0, 32'h20, 0, 3'd4);
    // 3: stores interleaved with unrelated loads, then half store and load
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h50 + 32'(4 * i), $urandom, 3'd4);
      step(1, 0, 32'h70, 0, 3'd4);
    end
    step(1, 1, 32'h42, 32'hFFFFABCD, 3'd2);
    step(0, 0, 0, 0, 3'd0);
    step(0, 0, 0, 0, 3'd0);
    step(1, 0, 32'h42, 0, 3'd2);
    step(1, 0, 32'h43, 0, 3'd2);
    // 4: byte overlay on a buffered word
    step(1, 1, 32'h30, 32'h01020304, 3'd4);
    step(1, 0, 32'h60, 0, 3'd4);
    step(1, 1, 32'h31, 32'h000000FF, 3'd1);
    step(1, 0, 32'h30, 0, 3'd4);
    step(1, 0, 32'h31, 0, 3'd1);
    step(1, 0, 32'h33, 0, 3'd1);
    // 5: address wrap aliases word 0
    step(1, 1, 32'h0, 32'hCAFEF00D, 3'd4);
    step(1, 1, 32'h4000, 32'h12345678, 3'd4);
    step(1, 0, 32'h0, 0, 3'd4);
    step(0, 0, 0, 0, 3'd0);
    step(1, 0, 32'h8000, 0, 3'd4);
    // 6: reset discards buffered stores; illegal size is a no-op
    step(1, 1, 32'h14, 32'hAAAAAAAA, 3'd4);
    step(1, 0, 32'h70, 0, 3'd4);
    step(1, 1, 32'h18, 32'hBBBBBBBB, 3'd4);
    step(1, 1, 32'h1C, 32'hCCCCCCCC, 3'd4);
    pulse_reset();
    step(1, 0, 32'h18, 0, 3'd4);
    step(1, 0, 32'h1C, 0, 3'd4);
    step(1, 0, 32'h1C, 0, 3'd3);
    step(1, 1, 32'h1C, 32'h99999999, 3'd3);
    step(1, 0, 32'h1C, 0, 3'd4);
    // randomized traffic over a small window with aliased upper address bits
    for (int c = 0; c < 600; c++) begin
      a = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) a = a + 32'h4000 * $urandom_range(1, 7);
      op = $urandom_range(0, 9);
      if (op < 2)      step(op == 1, 1'($urandom_range(0, 1)), a, $urandom, op == 1 ? 3'd3 : sizes[$urandom_range(0, 7)]);
      else if (op < 6) step(1, 0, a, 0, sizes[$urandom_range(0, 7)]);
      else             step(1, 1, a, $urandom, sizes[$urandom_range(0, 7)]);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end
    step(0, 0, 0, 0, 3'd0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
